// File: rtl/multiplicador_algoritmico.sv
// Sequential signed multiplier: sign-magnitude shift-and-add, one M1/M2 pair per multiplier bit.
// Operands are latched on the accepting edge; the product appears 2N+1 edges later with a one-cycle Done.
module multiplicador_algoritmico #(
  parameter int tamanyo = 32
) (
  input  logic                   CLK,
  input  logic                   RSTa,
  input  logic                   Start,
  input  logic [tamanyo-1:0]     A,
  input  logic [tamanyo-1:0]     B,
  output logic [2*tamanyo-1:0]   Prod,
  output logic                   Done,
  output logic                   Busy
);
  localparam int N  = tamanyo;
  localparam int N2 = 2 * tamanyo;
  localparam int CW = $clog2(tamanyo);

  typedef enum logic [1:0] {M0, M1, M2, M3} state_t;

  state_t          state_q, state_d;
  logic [N:0]      accu_q, accu_d;
  logic [N-1:0]    mplr_q, mplr_d;
  logic [N-1:0]    mcand_q, mcand_d;
  logic [CW-1:0]   cont_q, cont_d;
  logic            signa_q, signa_d;
  logic            signb_q, signb_d;
  logic [N2-1:0]   prod_q, prod_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic [N-1:0]    mag_a, mag_b;
  logic [N2-1:0]   p_mag;

  // -2^(N-1) negates to itself, which read as unsigned is the correct magnitude
  assign mag_a = A[N-1] ? (~A + N'(1)) : A;
  assign mag_b = B[N-1] ? (~B + N'(1)) : B;
  assign p_mag = {accu_q[N-1:0], mplr_q};

  always_ff @(posedge CLK) begin
    if (!RSTa) begin
      state_q <= M0;
      accu_q  <= '0;
      mplr_q  <= '0;
      mcand_q <= '0;
      cont_q  <= '0;
      signa_q <= 1'b0;
      signb_q <= 1'b0;
      prod_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      accu_q  <= accu_d;
      mplr_q  <= mplr_d;
      mcand_q <= mcand_d;
      cont_q  <= cont_d;
      signa_q <= signa_d;
      signb_q <= signb_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accu_d  = accu_q;
    mplr_d  = mplr_q;
    mcand_d = mcand_q;
    cont_d  = cont_q;
    signa_d = signa_q;
    signb_d = signb_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
    // Busy trails the state by one edge: set on the first add edge, dropped on the finish edge
    busy_d  = (state_q == M1) || (state_q == M2);
    case (state_q)
      M0: begin
        if (Start) begin
          signa_d = A[N-1];
          signb_d = B[N-1];
          mcand_d = mag_a;
          mplr_d  = mag_b;
          accu_d  = '0;
          cont_d  = CW'(N - 1);
          state_d = M1;
        end
      end
      M1: begin
        if (mplr_q[0]) accu_d = accu_q + {1'b0, mcand_q};
        state_d = M2;
      end
      M2: begin
        {accu_d, mplr_d} = {accu_q, mplr_q} >> 1;
        cont_d  = cont_q - CW'(1);
        state_d = (cont_q == '0) ? M3 : M1;
      end
      M3: begin
        prod_d  = (signa_q ^ signb_q) ? (~p_mag + N2'(1)) : p_mag;
        done_d  = 1'b1;
        state_d = M0;
      end
      default: state_d = M0;
    endcase
  end

  assign Prod = prod_q;
  assign Done = done_q;
  assign Busy = busy_q;

endmodule

// File: tb/tb_multiplicador_algoritmico.sv
// Randomized bench for the 8-bit sequential multiplier against an integer-arithmetic reference.
module tb_multiplicador_algoritmico;
  localparam int N = 8;

  logic           CLK = 1'b0;
  logic           RSTa = 1'b0;
  logic           Start = 1'b0;
  logic [N-1:0]   A = '0;
  logic [N-1:0]   B = '0;
  logic [2*N-1:0] Prod;
  logic           Done;
  logic           Busy;

  int n_chk  = 0;
  int n_pass = 0;

  multiplicador_algoritmico #(.tamanyo(N)) dut (
    .CLK(CLK), .RSTa(RSTa), .Start(Start), .A(A), .B(B),
    .Prod(Prod), .Done(Done), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int pa, pb;
    pa = $signed(a);
    pb = $signed(b);
    return 16'(pa * pb);
  endfunction

  // One operation from idle; optionally scramble operands and pulse Start mid-flight
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit disturb);
    logic [15:0] p0, exp;
    int lat, busy_n;
    bit seen, stable;
    lat = 0; busy_n = 0; seen = 0; stable = 1;
    exp = ref_mul(a, b);
    @(negedge CLK);
    A = a; B = b; Start = 1'b1; p0 = Prod;
    @(posedge CLK); #1;
    if (disturb) begin A = 8'($urandom); B = 8'($urandom); end
    Start = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge CLK); #1;
      lat = i;
      if (Busy) busy_n++;
      if (Done) seen = 1;
      else if (Prod !== p0) stable = 0;
      if (disturb && i == 4) begin Start = 1'b1; A = 8'($urandom); B = ~B; end
      if (disturb && i == 8) Start = 1'b0;
    end
    chk("latency", lat, 17);
    chk("busy_cycles", busy_n, 16);
    chk("prod_hold", {31'd0, stable}, 1);
    chk("prod", {16'd0, Prod}, {16'd0, exp});
    @(posedge CLK); #1;
    chk("done_pulse", {31'd0, Done}, 0);
  endtask

  initial begin
    logic [7:0] ta [8];
    logic [7:0] tb [8];
    logic [15:0] exp_b2b;
    int rem, nd, dn;

    // Reset held with Start asserted: nothing may be accepted
    RSTa = 1'b0; Start = 1'b1; A = 8'd7; B = 8'hFD;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_done", {31'd0, Done}, 0);
    chk("rst_busy", {31'd0, Busy}, 0);
    chk("rst_prod", {16'd0, Prod}, 0);
    @(negedge CLK);
    RSTa = 1'b1; Start = 1'b0;

    ta = '{8'd7, 8'h80, 8'h80, 8'd0, 8'hFF, 8'hFF, 8'd127, 8'h80};
    tb = '{8'hFD, 8'h80, 8'd127, 8'hFB, 8'd0, 8'hFF, 8'd127, 8'd1};
    for (int i = 0; i < 8; i++) do_op(ta[i], tb[i], 0);
    for (int i = 0; i < 20; i++) do_op(8'($urandom), 8'($urandom), 1'($urandom));

    // Abort mid-operation with a single reset edge
    @(negedge CLK);
    A = 8'd100; B = 8'd3; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (4) @(posedge CLK);
    #1; RSTa = 1'b0;
    @(posedge CLK); #1;
    chk("abort_done", {31'd0, Done}, 0);
    chk("abort_busy", {31'd0, Busy}, 0);
    chk("abort_prod", {16'd0, Prod}, 0);
    RSTa = 1'b1;
    dn = 0;
    repeat (25) begin
      @(posedge CLK); #1;
      if (Done) dn++;
    end
    chk("abort_no_done", dn, 0);
    do_op(8'd100, 8'd3, 0);

    // Start held high: accept every 18 edges, each result from its own operands
    @(negedge CLK);
    Start = 1'b1; A = 8'($urandom); B = 8'($urandom);
    rem = 0; nd = 0; exp_b2b = '0;
    for (int e = 0; e < 80; e++) begin
      @(posedge CLK);
      if (rem == 0) begin exp_b2b = ref_mul(A, B); rem = 17; end
      else rem--;
      #1;
      chk("b2b_done", {31'd0, Done}, {31'd0, rem == 0});
      if (rem == 0) begin
        nd++;
        chk("b2b_prod", {16'd0, Prod}, {16'd0, exp_b2b});
      end
      @(negedge CLK);
      A = 8'($urandom); B = 8'($urandom);
    end
    chk("b2b_pulses", nd, 4);
    Start = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multiplicador_algoritmico.md
MULTIPLICADOR_ALGORITMICO -- requirements
Module: multiplicador_algoritmico

Interface
REQ-001 Parameter: tamanyo, default 32, operand width N in bits; legal values are 4 to 64.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RSTa  input  1  reset; synchronous and active-low, sampled on the rising edge of CLK.
REQ-004 Start  input  1  request a new multiplication; sampled only in state M0.
REQ-005 A  input  N  multiplicand, two's complement signed; sampled on the accepting edge.
REQ-006 B  input  N  multiplier, two's complement signed; sampled on the accepting edge.
REQ-007 Prod  output  2N  signed product A*B; registered.
REQ-008 Done  output  1  one-cycle completion pulse; registered.
REQ-009 Busy  output  1  high in every state except M0; registered.

Function
REQ-010 The FSM SHALL have four states: M0 idle, M1 add, M2 shift, M3 finish.
REQ-011 In M0 with Start=1, the block SHALL latch SignA=A[N-1] and SignB=B[N-1], load MCAND=|A| and MPLR=|B| as N-bit unsigned values, clear ACCU (N+1 bits), set CONT=N-1, and go to M1.
REQ-012 Magnitude SHALL be computed as ~x+1 when x is negative; -2^(N-1) SHALL yield the unsigned magnitude 2^(N-1).
REQ-013 In M0 with Start=0, the block SHALL stay in M0 with no register changes except Done.
REQ-014 In M1, if MPLR[0]=1, the block SHALL set ACCU <= ACCU + MCAND, keeping the carry in ACCU[N]; it SHALL then go to M2.
REQ-015 In M2, the block SHALL shift {ACCU,MPLR} right by one, with a zero entering ACCU[N], and decrement CONT.
REQ-016 In M2, if CONT was 0 before the decrement, the next state SHALL be M3; otherwise it SHALL be M1.
REQ-017 There SHALL be exactly N M1/M2 pairs per operation.
REQ-018 In M3, the block SHALL set P={ACCU[N-1:0],MPLR}.
REQ-019 In M3, the block SHALL set Prod <= (SignA^SignB) ? (~P+1) : P, set Done <= 1, and go to M0.
REQ-020 Latency: with Start sampled at edge k, Done and Prod SHALL update at edge k+2N+1, and Busy SHALL be 1 from edge k+1 through edge k+2N.
REQ-021 Done SHALL be high for exactly one cycle; M0 SHALL clear Done on the next edge.
REQ-022 If Start=1 in the cycle Done is high (state M0), the block SHALL accept the new operation on that edge and clear Done in the same edge.
REQ-023 Start in M1, M2 or M3 SHALL be ignored; the operation in progress and the operands it latched SHALL NOT change.
REQ-024 Changes on A and B after the accepting edge SHALL have no effect on the result.
REQ-025 Prod SHALL hold its last value until the next M3; it SHALL NOT change during M1 or M2.
REQ-026 Zero operands SHALL yield Prod=0 regardless of sign; negating zero gives zero.
REQ-027 The full range SHALL be exact with no overflow: the largest magnitude, (-2^(N-1))*(-2^(N-1)) = 2^(2N-2), fits in 2N signed bits.
REQ-028 An illegal state encoding SHALL transition to M0 on the next edge.

Reset
REQ-029 At any edge with RSTa=0, the block SHALL force state=M0, Done=0, Busy=0, Prod=0, ACCU=0, MPLR=0, MCAND=0, CONT=0, SignA=0 and SignB=0.
REQ-030 Reset in mid-operation SHALL abort the operation with no Done pulse; Prod SHALL read 0.
REQ-031 While RSTa=0, Start SHALL be ignored; the first operation SHALL be accepted no earlier than the first edge with RSTa=1.

Verification (tamanyo=8)
REQ-032 A=7, B=-3, Start for 1 cycle -> Done pulses once 17 edges after acceptance with Prod=16'hFFEB (-21); Busy is high for 16 cycles.
REQ-033 A=-128, B=-128 -> Prod=16'h4000 (16384); A=-128, B=127 -> Prod=16'hC080 (-16256).
REQ-034 A=0, B=-5, then A=-1, B=0 -> Prod=0 for both; A=-1, B=-1 -> Prod=1.
REQ-035 Start pulsed in M1/M2 with different A/B mid-operation -> the result still matches the first operands; Done pulses exactly once.
REQ-036 RSTa=0 for one edge at cycle 5 of an operation -> no Done pulse, Prod=0 and Busy=0; a following Start produces a correct result.
REQ-037 Start held high continuously -> back-to-back operations with one Done pulse every 18 cycles; each Prod is correct for the operands sampled at its own accepting edge.
